// File: rtl/srl_fifo_if.sv
// Stream interface for srl_fifo: write side, read side and occupancy.
// Honours SRL_FIFO_OUTREG_EN so the level width matches the FIFO build.
interface srl_fifo_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
`ifdef SRL_FIFO_OUTREG_EN
    localparam int AW = $clog2(DEPTH + 2);
`else
    localparam int AW = $clog2(DEPTH + 1);
`endif

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [AW-1:0]    level;

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, level
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, level
    );
endinterface

// File: rtl/srl_fifo.sv
// srl_fifo: first-word-fall-through FIFO built on an unreset shift array so it maps onto SRL16E/SRLC32E.
// Define SRL_FIFO_OUTREG_EN to add a one-entry registered output stage (capacity DEPTH+1).
module srl_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic      clk,
    input  logic      r,
    srl_fifo_if.slave q
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
`ifdef SRL_FIFO_OUTREG_EN
    localparam int AW  = $clog2(DEPTH + 2);
    localparam int CAP = DEPTH + 1;
`else
    localparam int AW  = $clog2(DEPTH + 1);
    localparam int CAP = DEPTH;
`endif
    localparam logic [AW-1:0] CAP_L  = AW'(CAP);
    localparam logic [AW-1:0] ZERO_L = {AW{1'b0}};
    localparam logic [AW-1:0] ONE_L  = {{(AW-1){1'b0}}, 1'b1};

    logic [WIDTH-1:0] sreg [DEPTH];
    logic [AW-1:0]    level_r;
    logic [AW-1:0]    level_nxt_s;
    logic [AW-1:0]    arr_cnt_s;
    logic [IW-1:0]    tap_idx_s;
    logic [WIDTH-1:0] tap_data_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             wr_s;
    logic             rd_s;

    assign in_ready_s = ~r & (level_r != CAP_L);
    assign wr_s       = q.in_valid & in_ready_s;
    assign rd_s       = out_valid_s & q.out_ready;

    // Shift chain: the write strobe is its only control, keeping it SRL-mappable.
    always_ff @(posedge clk) begin
        if (wr_s) begin
            sreg[0] <= q.in_data;
            for (int k = 1; k < DEPTH; k++) begin
                sreg[k] <= sreg[k-1];
            end
        end
    end

    // Dynamic tap points at the oldest word still held in the array.
    always_comb begin
        if (arr_cnt_s != ZERO_L) begin
            tap_idx_s = IW'(arr_cnt_s - ONE_L);
        end else begin
            tap_idx_s = {IW{1'b0}};
        end
    end

    assign tap_data_s = sreg[tap_idx_s];

    // Total occupancy: accepted writes minus consumed reads.
    always_comb begin
        case ({wr_s, rd_s})
            2'b10:   level_nxt_s = level_r + ONE_L;
            2'b01:   level_nxt_s = level_r - ONE_L;
            default: level_nxt_s = level_r;
        endcase
    end

    // Level register, cleared by the synchronous reset.
    always_ff @(posedge clk) begin
        if (r) begin
            level_r <= ZERO_L;
        end else begin
            level_r <= level_nxt_s;
        end
    end

`ifdef SRL_FIFO_OUTREG_EN
    logic [AW-1:0]    arr_cnt_r;
    logic [AW-1:0]    arr_cnt_nxt_s;
    logic             ovalid_r;
    logic [WIDTH-1:0] odata_r;
    logic             load_s;

    // The skid register refills from the tap whenever it is empty or being drained.
    assign load_s = (~ovalid_r | rd_s) & (arr_cnt_r != ZERO_L);

    // Array-only occupancy: writes push in, loads into the skid register pop out.
    always_comb begin
        case ({wr_s, load_s})
            2'b10:   arr_cnt_nxt_s = arr_cnt_r + ONE_L;
            2'b01:   arr_cnt_nxt_s = arr_cnt_r - ONE_L;
            default: arr_cnt_nxt_s = arr_cnt_r;
        endcase
    end

    // Array count register.
    always_ff @(posedge clk) begin
        if (r) begin
            arr_cnt_r <= ZERO_L;
        end else begin
            arr_cnt_r <= arr_cnt_nxt_s;
        end
    end

    // Output valid flag of the skid register.
    always_ff @(posedge clk) begin
        if (r) begin
            ovalid_r <= 1'b0;
        end else if (load_s) begin
            ovalid_r <= 1'b1;
        end else if (rd_s) begin
            ovalid_r <= 1'b0;
        end
    end

    // Output data of the skid register; not reset, qualified by ovalid_r.
    always_ff @(posedge clk) begin
        if (load_s) begin
            odata_r <= tap_data_s;
        end
    end

    assign arr_cnt_s   = arr_cnt_r;
    assign out_valid_s = ovalid_r;
    assign q.out_data  = odata_r;
`else
    logic out_valid_r;

    // Registered non-empty flag, computed from the next level.
    always_ff @(posedge clk) begin
        if (r) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= (level_nxt_s != ZERO_L);
        end
    end

    assign arr_cnt_s   = level_r;
    assign out_valid_s = out_valid_r;
    assign q.out_data  = tap_data_s;
`endif

    assign q.in_ready  = in_ready_s;
    assign q.out_valid = out_valid_s;
    assign q.level     = level_r;
endmodule
